// File: rtl/ic_pkg.sv
// Shared interconnect types: write-scheduler entry, default widths, clog2 helper.
package ic_pkg;

  localparam int MSTR_BITS = 2;
  localparam int LEN_BITS  = 4;

  // One outstanding write burst: owning master and AWLEN.
  typedef struct packed {
    logic [MSTR_BITS-1:0] mstr;
    logic [LEN_BITS-1:0]  len;
  } wsched_entry_t;

  // Index width for n items, never below 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ic_wr_sched_fifo.sv
// Register FIFO of write-burst entries, kept in AW-accept order.
module ic_wr_sched_fifo
  import ic_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  wsched_entry_t       push_data,
  input  logic                pop,
  output wsched_entry_t       head,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  localparam int AW = CNT_BITS - 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_BITS-1:0] wr_ptr, rd_ptr;
  wsched_entry_t       mem [DEPTH];
  logic                do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push while full is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ic_wr_sched.sv
// Per-slave W-channel scheduler: serves masters' write data in AW-accept order.
module ic_wr_sched
  import ic_pkg::*;
#(
  parameter int NUM_MSTR  = 4,
  parameter int MSTR_BITS = ic_pkg::MSTR_BITS,
  parameter int LEN_BITS  = ic_pkg::LEN_BITS,
  parameter int DEPTH     = 4,
  parameter int CNT_BITS  = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aw_valid,
  input  logic                 aw_ready,
  input  logic [MSTR_BITS-1:0] aw_mstr,
  input  logic [LEN_BITS-1:0]  aw_len,
  output logic                 aw_hold,
  input  logic [NUM_MSTR-1:0]  m_wvalid,
  input  logic [NUM_MSTR-1:0]  m_wlast,
  output logic [NUM_MSTR-1:0]  m_wready,
  output logic                 s_wvalid,
  output logic                 s_wlast,
  input  logic                 s_wready,
  output logic [MSTR_BITS-1:0] w_sel,
  output logic                 w_sel_ok,
  output logic [CNT_BITS-1:0]  pending,
  output logic                 err_last
);

  wsched_entry_t       aw_e, head;
  logic                full, empty, push, pop, beat, last_beat;
  logic [LEN_BITS-1:0] beat_cnt;

  assign aw_e = '{mstr: aw_mstr, len: aw_len};
  assign push = aw_valid & aw_ready & ~full;

  ic_wr_sched_fifo #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (aw_e),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // Hold comes straight from registered fullness; a same-cycle pop does not bypass it.
  assign aw_hold   = full;
  assign w_sel_ok  = ~empty;
  assign w_sel     = empty ? '0 : head.mstr;
  assign s_wvalid  = w_sel_ok & m_wvalid[w_sel];
  assign s_wlast   = w_sel_ok & m_wlast[w_sel];
  assign beat      = s_wvalid & s_wready;
  assign last_beat = (beat_cnt == head.len);
  // Retire on length, not on WLAST.
  assign pop       = beat & last_beat;

  // Only the head master sees WREADY.
  for (genvar i = 0; i < NUM_MSTR; i++) begin : g_wready
    assign m_wready[i] = w_sel_ok & s_wready & (w_sel == MSTR_BITS'(i));
  end

  // Beat counter within the head burst, plus registered WLAST/length check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      err_last <= 1'b0;
    end else begin
      err_last <= beat & (m_wlast[w_sel] != last_beat);
      if (pop)       beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Upstream must gate AWVALID on aw_hold; an AW taken while full is lost.
  a_no_aw_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(aw_valid && aw_ready && full));

endmodule

// File: tb/tb_ic_wr_sched.sv
// Directed bench for ic_wr_sched with hand-computed expectations.
module tb_ic_wr_sched;

  logic       clk, reset;
  logic       aw_valid, aw_ready, aw_hold;
  logic [1:0] aw_mstr;
  logic [3:0] aw_len;
  logic [3:0] m_wvalid, m_wlast, m_wready;
  logic       s_wvalid, s_wlast, s_wready;
  logic [1:0] w_sel;
  logic       w_sel_ok;
  logic [2:0] pending;
  logic       err_last;

  int n_run, n_fail;

  ic_wr_sched dut (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_mstr(aw_mstr), .aw_len(aw_len),
    .aw_hold(aw_hold),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
    .w_sel(w_sel), .w_sel_ok(w_sel_ok), .pending(pending), .err_last(err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One AW handshake; returns 1ns after the accepting edge.
  task automatic do_aw(input logic [1:0] m, input logic [3:0] len);
    aw_valid = 1'b1; aw_ready = 1'b1; aw_mstr = m; aw_len = len;
    @(posedge clk); #1;
    aw_valid = 1'b0; aw_ready = 1'b0; aw_mstr = '0; aw_len = '0;
  endtask

  task automatic idle_w();
    m_wvalid = '0; m_wlast = '0; s_wready = 1'b0;
  endtask

  logic [3:0] ord_exp [4];

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b0; aw_valid = 0; aw_ready = 0; aw_mstr = 0; aw_len = 0;
    idle_w();
    #2;
    chk("rst_hold",  aw_hold,  0);
    chk("rst_wrdy",  m_wready, 0);
    chk("rst_svld",  s_wvalid, 0);
    chk("rst_slast", s_wlast,  0);
    chk("rst_sel",   w_sel,    0);
    chk("rst_selok", w_sel_ok, 0);
    chk("rst_pend",  pending,  0);
    chk("rst_err",   err_last, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single burst: master 2, 4 beats.
    do_aw(2'd2, 4'd3);
    @(negedge clk);
    chk("t1_selok", w_sel_ok, 1);
    chk("t1_sel",   w_sel,    2);
    chk("t1_pend",  pending,  1);
    chk("t1_wrdy0", m_wready, 0);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      m_wvalid = 4'b0100; m_wlast = (b == 3) ? 4'b0100 : 4'b0000; s_wready = 1'b1;
      @(negedge clk);
      chk("t1_wrdy",  m_wready, 4'b0100);
      chk("t1_svld",  s_wvalid, 1);
      chk("t1_slast", s_wlast,  (b == 3));
      chk("t1_pend_b", pending, 1);
      chk("t1_err_b", err_last, 0);
      @(posedge clk); #1;
    end
    idle_w();
    @(negedge clk);
    chk("t1_pend_end", pending,  0);
    chk("t1_err_end",  err_last, 0);
    chk("t1_selok_end", w_sel_ok, 0);
    @(posedge clk); #1;

    // Ordering: 1(len0), 3(len1), 1(len0) -> grants 1,3,3,1.
    do_aw(2'd1, 4'd0);
    do_aw(2'd3, 4'd1);
    do_aw(2'd1, 4'd0);
    ord_exp[0] = 4'b0010; ord_exp[1] = 4'b1000; ord_exp[2] = 4'b1000; ord_exp[3] = 4'b0010;
    m_wvalid = 4'hF; m_wlast = 4'hF; s_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("t2_grant", m_wready, ord_exp[b]);
      @(posedge clk); #1;
    end
    idle_w();
    @(negedge clk);
    chk("t2_pend_end", pending, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Full and hold.
    for (int k = 0; k < 4; k++) do_aw(2'd0, 4'd0);
    @(negedge clk);
    chk("t3_pend_full", pending, 4);
    chk("t3_hold",      aw_hold, 1);
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_mstr = 2'd3; aw_len = 4'd0;
    m_wvalid = 4'b0001; m_wlast = 4'b0001; s_wready = 1'b1;
    @(negedge clk);
    chk("t3_hold_popcyc", aw_hold,  1);
    chk("t3_wrdy_pop",    m_wready, 4'b0001);
    @(posedge clk); #1;
    idle_w();
    @(negedge clk);
    chk("t3_hold_after", aw_hold, 0);
    chk("t3_pend_3",     pending, 3);
    @(posedge clk); #1;
    aw_valid = 1'b0; aw_mstr = '0;
    m_wvalid = 4'b0001; m_wlast = 4'b0001; s_wready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    idle_w();
    @(negedge clk);
    chk("t3_drain", pending, 0);
    chk("t3_err",   err_last, 0);
    @(posedge clk); #1;

    // Early WLAST on beat 2 of a len=2 burst.
    do_aw(2'd1, 4'd2);
    for (int b = 0; b < 3; b++) begin
      m_wvalid = 4'b0010; m_wlast = (b >= 1) ? 4'b0010 : 4'b0000; s_wready = 1'b1;
      @(negedge clk);
      chk("t4_err_b", err_last, (b == 2));
      chk("t4_pend_b", pending, 1);
      @(posedge clk); #1;
    end
    idle_w();
    @(negedge clk);
    chk("t4_err_end", err_last, 0);
    chk("t4_pend_end", pending, 0);
    @(posedge clk); #1;

    // len=0 without WLAST: error pulse, still pops.
    do_aw(2'd0, 4'd0);
    m_wvalid = 4'b0001; m_wlast = 4'b0000; s_wready = 1'b1;
    @(posedge clk); #1;
    idle_w();
    @(negedge clk);
    chk("t4b_err",  err_last, 1);
    chk("t4b_pend", pending,  0);
    @(negedge clk);
    chk("t4b_err_clr", err_last, 0);
    @(posedge clk); #1;

    // Backpressure: handshakes on cycles 0,2,4,6 of a len=3 burst.
    do_aw(2'd3, 4'd3);
    for (int c = 0; c < 7; c++) begin
      m_wvalid = 4'b1000; m_wlast = (c == 6) ? 4'b1000 : 4'b0000; s_wready = (c % 2 == 0);
      @(negedge clk);
      chk("t5_pend", pending, 1);
      chk("t5_wrdy", m_wready, (c % 2 == 0) ? 4'b1000 : 4'b0000);
      @(posedge clk); #1;
    end
    idle_w();
    @(negedge clk);
    chk("t5_pend_end", pending,  0);
    chk("t5_err",      err_last, 0);
    @(posedge clk); #1;

    // Reset mid-burst with two entries queued.
    do_aw(2'd2, 4'd3);
    do_aw(2'd1, 4'd0);
    m_wvalid = 4'b0100; m_wlast = 4'b0000; s_wready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("t6_selok", w_sel_ok, 0);
    chk("t6_wrdy",  m_wready, 0);
    chk("t6_svld",  s_wvalid, 0);
    chk("t6_pend",  pending,  0);
    chk("t6_sel",   w_sel,    0);
    @(negedge clk); reset = 1'b1;
    idle_w();
    @(negedge clk);
    chk("t6_pend_rel", pending, 0);
    @(posedge clk); #1;
    do_aw(2'd2, 4'd1);
    for (int b = 0; b < 2; b++) begin
      m_wvalid = 4'b0100; m_wlast = (b == 1) ? 4'b0100 : 4'b0000; s_wready = 1'b1;
      @(negedge clk);
      chk("t6_pend_b", pending, 1);
      chk("t6_err_b",  err_last, 0);
      @(posedge clk); #1;
    end
    idle_w();
    @(negedge clk);
    chk("t6_pend_end", pending,  0);
    chk("t6_err_end",  err_last, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
